seq_counter_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the counter-to-data decode stage. It generates the 3-bit `counter` index that the decoder turns into an 8-bit sequence byte, and it paces the index with a valid/ready handshake toward the consumer. It runs the sequence once, a programmed number of times, or until stopped, and reports completion.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_counter_ctrl.sv | 105 ++++++++++
 tb/tb_seq_counter_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence generator.
// Holds the controller state encoding and index width.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int SEQ_CNT_W   = 3;
   localparam int SEQ_LEN_MAX = 8;

endpackage

// File: rtl/seq_counter_ctrl.sv
// Sequencing controller: paces a 3-bit index toward the decoder
// with valid/ready, for one, N, or unlimited passes.
// Ports: clk, rst_n (sync, active-low), start, stop, loop_count,
//        out_ready -> counter, out_valid, busy, done, loop_idx.
module seq_counter_ctrl
   import seq_pkg::*;
#(
   parameter int SEQ_LEN = 8,
   parameter int LOOP_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [LOOP_W-1:0]    loop_count,
   input  logic                 out_ready,
   output logic [SEQ_CNT_W-1:0] counter,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 done,
   output logic [LOOP_W-1:0]    loop_idx
);

   localparam logic [SEQ_CNT_W-1:0] LAST =
      SEQ_CNT_W'(SEQ_LEN - 1);

   seq_state_t            state_q, state_d;
   logic [SEQ_CNT_W-1:0]  cnt_q, cnt_d;
   logic [LOOP_W-1:0]     lidx_q, lidx_d;
   logic [LOOP_W-1:0]     lcnt_q, lcnt_d;
   logic [LOOP_W:0]       nxt_pass;
   logic                  hs;
   logic                  more;

   // One extra bit so a max loop_count cannot wrap the compare.
   assign nxt_pass = {1'b0, lidx_q} + (LOOP_W+1)'(1);
   assign more     = (lcnt_q == '0) ||
                     (nxt_pass < {1'b0, lcnt_q});
   assign hs       = (state_q == RUN) & out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lidx_d  = lidx_q;
      lcnt_d  = lcnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            lidx_d = '0;
            if (start && !stop) begin
               lcnt_d  = loop_count;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               cnt_d   = '0;
               lidx_d  = '0;
               state_d = IDLE;
            end else if (hs) begin
               if (cnt_q != LAST) begin
                  cnt_d = cnt_q + SEQ_CNT_W'(1);
               end else if (more) begin
                  cnt_d  = '0;
                  lidx_d = lidx_q + LOOP_W'(1);
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            lidx_d  = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            lidx_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lidx_q  <= '0;
         lcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lidx_q  <= lidx_d;
         lcnt_q  <= lcnt_d;
      end
   end

   // Outputs decode straight from registers only.
   assign counter   = cnt_q;
   assign loop_idx  = lidx_q;
   assign out_valid = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl.
// Two instances: SEQ_LEN=8 and SEQ_LEN=5.
module tb_seq_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic       start5 = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] loop_count = 4'd0;
   logic       out_ready = 1'b0;

   logic [2:0] counter8, counter5;
   logic       out_valid8, out_valid5;
   logic       busy8, busy5;
   logic       done8, done5;
   logic [3:0] loop_idx8, loop_idx5;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_counter_ctrl #(.SEQ_LEN(8), .LOOP_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop),
      .loop_count(loop_count), .out_ready(out_ready),
      .counter(counter8), .out_valid(out_valid8),
      .busy(busy8), .done(done8), .loop_idx(loop_idx8)
   );

   seq_counter_ctrl #(.SEQ_LEN(5), .LOOP_W(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .stop(stop),
      .loop_count(loop_count), .out_ready(out_ready),
      .counter(counter5), .out_valid(out_valid5),
      .busy(busy5), .done(done5), .loop_idx(loop_idx5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({counter8, out_valid8, busy8, done8, loop_idx8}
             !== 10'd0) begin
            failures++;
            $display("FAIL reset8 cyc%0d got c=%0d v=%b b=%b d=%b l=%0d want all 0",
                     i, counter8, out_valid8, busy8, done8, loop_idx8);
         end
         checks++;
         if ({counter5, out_valid5, busy5, done5, loop_idx5}
             !== 10'd0) begin
            failures++;
            $display("FAIL reset5 cyc%0d got c=%0d v=%b b=%b d=%b want all 0",
                     i, counter5, out_valid5, busy5, done5);
         end
         tick();
      end
   endtask

   task automatic test_single_pass();
      loop_count = 4'd1;
      out_ready  = 1'b1;
      start8     = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (counter8 !== 3'(i) || out_valid8 !== 1'b1 ||
             busy8 !== 1'b1 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL single idx%0d got c=%0d v=%b b=%b d=%b want c=%0d v=1 b=1 d=0",
                     i, counter8, out_valid8, busy8, done8, i);
         end
         tick();
      end
      checks++;
      if (done8 !== 1'b1 || out_valid8 !== 1'b0 ||
          busy8 !== 1'b1 || counter8 !== 3'd7) begin
         failures++;
         $display("FAIL single_done got d=%b v=%b b=%b c=%0d want d=1 v=0 b=1 c=7",
                  done8, out_valid8, busy8, counter8);
      end
      tick();
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 ||
          counter8 !== 3'd0 || out_valid8 !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got b=%b d=%b c=%0d v=%b want b=0 d=0 c=0 v=0",
                  busy8, done8, counter8, out_valid8);
      end
   endtask

   task automatic test_backpressure();
      int exp;
      bit seen_done;
      bit rdy;
      exp = 0;
      seen_done = 1'b0;
      loop_count = 4'd1;
      out_ready  = 1'b1;
      start8     = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         out_ready = (c % 3 == 0);
         if (done8) begin
            seen_done = 1'b1;
         end else begin
            checks++;
            if (out_valid8 !== 1'b1 || counter8 !== 3'(exp)) begin
               failures++;
               $display("FAIL bp cyc%0d got v=%b c=%0d want v=1 c=%0d",
                        c, out_valid8, counter8, exp);
            end
            rdy = out_ready;
            tick();
            if (rdy) exp++;
         end
      end
      checks++;
      if (!seen_done || exp != 8) begin
         failures++;
         $display("FAIL bp_end got done_seen=%b handshakes=%0d want 1 and 8",
                  seen_done, exp);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic run5(input int passes);
      loop_count = 4'(passes);
      out_ready  = 1'b1;
      start5     = 1'b1;
      tick();
      start5 = 1'b0;
      for (int h = 0; h < passes * 5; h++) begin
         checks++;
         if (counter5 !== 3'(h % 5) ||
             loop_idx5 !== 4'(h / 5) ||
             out_valid5 !== 1'b1 || done5 !== 1'b0) begin
            failures++;
            $display("FAIL loop%0d hs%0d got c=%0d l=%0d v=%b d=%b want c=%0d l=%0d v=1 d=0",
                     passes, h, counter5, loop_idx5, out_valid5,
                     done5, h % 5, h / 5);
         end
         tick();
      end
      checks++;
      if (done5 !== 1'b1 || counter5 !== 3'd4 ||
          out_valid5 !== 1'b0) begin
         failures++;
         $display("FAIL loop%0d_done got d=%b c=%0d v=%b want d=1 c=4 v=0",
                  passes, done5, counter5, out_valid5);
      end
      tick();
      checks++;
      if (busy5 !== 1'b0 || done5 !== 1'b0) begin
         failures++;
         $display("FAIL loop%0d_idle got b=%b d=%b want b=0 d=0",
                  passes, busy5, done5);
      end
   endtask

   task automatic test_loops();
      run5(3);
      run5(15);
   endtask

   task automatic test_infinite_stop();
      bit any_done;
      any_done = 1'b0;
      loop_count = 4'd0;
      out_ready  = 1'b1;
      start8     = 1'b1;
      tick();
      start8 = 1'b0;
      for (int h = 0; h < 19; h++) begin
         if (done8) any_done = 1'b1;
         tick();
      end
      checks++;
      if (counter8 !== 3'd3 || loop_idx8 !== 4'd2 ||
          out_valid8 !== 1'b1) begin
         failures++;
         $display("FAIL inf_pos got c=%0d l=%0d v=%b want c=3 l=2 v=1",
                  counter8, loop_idx8, out_valid8);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0 || counter8 !== 3'd0 ||
          busy8 !== 1'b0 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL stop got v=%b c=%0d b=%b d=%b want v=0 c=0 b=0 d=0",
                  out_valid8, counter8, busy8, done8);
      end
      tick();
      checks++;
      if (any_done || done8 !== 1'b0) begin
         failures++;
         $display("FAIL inf_nodone got done seen=%b now=%b want 0",
                  any_done, done8);
      end
   endtask

   task automatic test_edges();
      loop_count = 4'd1;
      out_ready  = 1'b1;
      start8 = 1'b1;
      stop   = 1'b1;
      tick();
      start8 = 1'b0;
      stop   = 1'b0;
      checks++;
      if (busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
         failures++;
         $display("FAIL start_stop got b=%b v=%b want b=0 v=0",
                  busy8, out_valid8);
      end
      start8 = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (counter8 !== 3'd2 || out_valid8 !== 1'b1) begin
         failures++;
         $display("FAIL start_in_run got c=%0d v=%b want c=2 v=1",
                  counter8, out_valid8);
      end
      start8 = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (counter8 !== 3'd5) begin
         failures++;
         $display("FAIL pre_reset got c=%0d want 5", counter8);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({counter8, out_valid8, busy8, done8, loop_idx8}
          !== 10'd0) begin
         failures++;
         $display("FAIL mid_reset got c=%0d v=%b b=%b d=%b l=%0d want all 0",
                  counter8, out_valid8, busy8, done8, loop_idx8);
      end
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got b=%b v=%b want b=0 v=0",
                  busy8, out_valid8);
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_backpressure();
      test_loops();
      test_infinite_stop();
      test_edges();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
